pipelined_seg_adder: RTL and testbench
======================================

Name: pipelined_seg_adder

Overview:
- Parametrised, pipelined successor to the single-cycle 48-bit carry adder in the MAF datapath.
- Splits the WIDTH-bit add/subtract into NSEG carry-linked segments, one segment per pipeline stage, with registered carry between stages.
- Accepts one operation per cycle under valid/ready flow control.
- Feeds the normaliser after the multiplier/aligner; adds a subtract mode and a zero flag.

Parameters:
- WIDTH, 48, sum width; x is WIDTH+1 bits, y is WIDTH bits.
- NSEG, 4, number of segments and pipeline stages; WIDTH % NSEG must be 0 (elaboration error otherwise).
- SEG_W, WIDTH/NSEG, segment width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  WIDTH+1  operand A (bit WIDTH is the pre-carry from the aligner).
- y  in  WIDTH  operand B.
- sub  in  1  0: x+y; 1: x-y.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result bits [WIDTH-1:0].
- cout  out  1  result bit WIDTH.
- zero  out  1  sum == 0 (cout is ignored).
- lzc  out  clog2(WIDTH+1)  leading-zero count of sum; present only with SEG_ADDER_LZC_EN.

Behaviour:
- Arithmetic, (WIDTH+1)-bit modular:
  - sub=0: r = x + {1'b0,y}.
  - sub=1: r = x + ~{1'b0,y} + 1.
  - sum = r[WIDTH-1:0]; cout = r[WIDTH]. For sub, cout=1 means a negative result or borrow.
- Segmentation:
  - Stage k (k=0..NSEG-1) adds segment k bits [(k+1)*SEG_W-1 : k*SEG_W] and the carry registered from stage k-1.
  - Stage 0 carry-in = sub.
  - The last stage adds x[WIDTH] and ~sub-adjusted bit into the final carry to form cout.
  - Not-yet-used operand segments are skewed forward in registers.
  - No combinational carry path spans more than one segment.
- Latency: exactly NSEG cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stalls.
- Throughput: 1 beat/cycle.
- Flow control:
  - Global advance enable en = !out_valid | out_ready; in_ready = en.
  - When en=0, all stages hold, including the valid bits, data and carries.
  - Bubbles propagate as invalid stages; they are not collapsed.
  - out_valid, sum, cout and zero hold stable while out_valid & !out_ready.
  - A beat presented with in_valid & !in_ready is not captured; the upstream must hold it.
- Simultaneous events: an out_ready handshake and an in_valid in the same cycle both complete; the pipeline shifts by one.
- Reset (rst_n=0 at the clk edge):
  - All stage valids, out_valid, sum, cout, zero and lzc clear to 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is emitted.
- zero: computed in the final stage from the full registered sum, aligned with out_valid.

Optional Feature:
- Macro: SEG_ADDER_LZC_EN.
- With the macro:
  - Port lzc exists; lzc = number of leading zeros of sum (cout excluded), range 0..WIDTH.
  - lzc is registered in the same final stage as sum, so latency is unchanged.
  - lzc resets to 0.
- Without the macro: port lzc and its logic are absent; everything else is identical.

Test Plan:
- Carry ripple across all segments (WIDTH=48, NSEG=4): x=0x0_FFFF_FFFF_FFFF, y=1, sub=0 -> after 4 cycles sum=0, cout=1, zero=1.
- Pre-carry and subtract:
  - x=0x1_0000_0000_0000, y=0, sub=0 -> sum=0, cout=1.
  - x=5, y=7, sub=1 -> sum=0xFFFF_FFFF_FFFE, cout=1, zero=0.
- Back-to-back: 8 consecutive beats with x=i, y=i (i=0..7), out_ready=1 -> out_valid high for 8 cycles, starting at cycle 4, with sums 0,2,...,14 in order and no gaps.
- Backpressure:
  - Stream 6 beats and drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 in those cycles.
  - The held result is stable; no beat is lost or duplicated; order is preserved.
- Reset mid-flight: assert rst_n=0 for 1 cycle while 3 beats are in flight -> out_valid=0 next cycle, no stale results afterwards, in_ready=1.
- SEG_ADDER_LZC_EN: x=0x0_0000_0001_0000, y=0 -> lzc=31; x=0, y=0 -> lzc=48, zero=1.

Source files
------------

// File: rtl/pipelined_seg_adder_if.sv
// Operand/result handshake bundle for pipelined_seg_adder.
// The lzc signal exists only when SEG_ADDER_LZC_EN is defined.
interface pipelined_seg_adder_if #(
    parameter int unsigned WIDTH = 48
);
    localparam int unsigned LZC_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
`ifdef SEG_ADDER_LZC_EN
    logic [LZC_W-1:0] lzc;

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, sum, cout, zero, lzc
    );
    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, sum, cout, zero, lzc
    );
`else
    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, sum, cout, zero
    );
    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, sum, cout, zero
    );
`endif
endinterface

// File: rtl/pipelined_seg_adder.sv
// Pipelined (WIDTH+1)-bit add/subtract split into NSEG carry-linked segments,
// one segment per stage, valid/ready flow control with a global stall.
// Optional leading-zero count output: define SEG_ADDER_LZC_EN.
module pipelined_seg_adder #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned NSEG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_seg_adder_if.slave  bus
);
    localparam int unsigned SEG_W   = WIDTH / NSEG;
    // Stage k keeps sum bits [(k+1)*SEG_W-1:0]; all stages are packed back to back.
    localparam int unsigned SUM_TOT = SEG_W * NSEG * (NSEG + 1) / 2;
    localparam int unsigned SUM_LO  = SEG_W * (NSEG - 1) * NSEG / 2;
    // Stage k (not last) keeps operand bits [WIDTH:(k+1)*SEG_W] still to be added.
    localparam int unsigned REM_TOT = (NSEG - 1) * (WIDTH + 1) - SUM_LO;
    localparam int unsigned REM_W   = (REM_TOT == 0) ? 1 : REM_TOT;

    if ((WIDTH % NSEG) != 0) begin : g_bad_cfg
        $error("pipelined_seg_adder: WIDTH must be a multiple of NSEG");
    end

    logic                en_c;
    logic [WIDTH:0]      b_in_c;
    logic [NSEG-1:0]     vld_q, vld_d;
    logic [NSEG-1:0]     cry_q, cry_d;
    logic [SUM_TOT-1:0]  sum_q, sum_d;
    logic [REM_W-1:0]    xr_q, xr_d;
    logic [REM_W-1:0]    br_q, br_d;
    logic                zero_q, zero_d;

    // Global advance: every stage moves unless a finished result is blocked.
    assign en_c   = !vld_q[NSEG-1] | bus.out_ready;
    // Subtract becomes add of the inverted operand plus carry-in at stage 0.
    assign b_in_c = bus.sub ? ~{1'b0, bus.y} : {1'b0, bus.y};

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int unsigned IW = WIDTH + 1 - k * SEG_W;
        localparam int unsigned SO = SEG_W * k * (k + 1) / 2;
        localparam int unsigned SW = (k + 1) * SEG_W;

        logic [IW-1:0]  xi_c, bi_c;
        logic           ci_c, vi_c;
        logic [SEG_W:0] seg_c;

        if (k == 0) begin : g_first
            assign xi_c            = bus.x;
            assign bi_c            = b_in_c;
            assign ci_c            = bus.sub;
            assign vi_c            = bus.in_valid;
            assign sum_d[SW-1:0]   = seg_c[SEG_W-1:0];
        end else begin : g_next
            localparam int unsigned PSO = SEG_W * (k - 1) * k / 2;
            localparam int unsigned PRO = (k - 1) * (WIDTH + 1) - PSO;
            assign xi_c            = xr_q[PRO +: IW];
            assign bi_c            = br_q[PRO +: IW];
            assign ci_c            = cry_q[k-1];
            assign vi_c            = vld_q[k-1];
            assign sum_d[SO +: SW] = {seg_c[SEG_W-1:0], sum_q[PSO +: k*SEG_W]};
        end

        // One segment-wide adder per stage; carry never ripples past it.
        assign seg_c    = (SEG_W+1)'(xi_c[SEG_W-1:0]) + (SEG_W+1)'(bi_c[SEG_W-1:0])
                        + (SEG_W+1)'(ci_c);
        assign vld_d[k] = vi_c;

        if (k < NSEG - 1) begin : g_mid
            localparam int unsigned RO = k * (WIDTH + 1) - SO;
            localparam int unsigned RW = IW - SEG_W;
            assign cry_d[k]        = seg_c[SEG_W];
            assign xr_d[RO +: RW]  = xi_c[IW-1:SEG_W];
            assign br_d[RO +: RW]  = bi_c[IW-1:SEG_W];
        end else begin : g_last
            // Top bit: fold in the aligner pre-carry and the extended operand bit.
            assign cry_d[k] = seg_c[SEG_W] ^ xi_c[SEG_W] ^ bi_c[SEG_W];
        end
    end

    assign zero_d = (sum_d[SUM_LO +: WIDTH] == '0);

`ifdef SEG_ADDER_LZC_EN
    localparam int unsigned LZC_W = $clog2(WIDTH + 1);
    logic [LZC_W-1:0] lzc_q, lzc_d;

    function automatic logic [LZC_W-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [LZC_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + LZC_W'(1);
        end
        return n;
    endfunction

    assign lzc_d   = count_lz(sum_d[SUM_LO +: WIDTH]);
    assign bus.lzc = lzc_q;

    // Leading-zero count registered alongside the final sum.
    always_ff @(posedge clk) begin
        if (!rst_n)    lzc_q <= '0;
        else if (en_c) lzc_q <= lzc_d;
    end
`endif

    // Pipeline registers: cleared by reset, frozen as a whole when stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cry_q  <= '0;
            sum_q  <= '0;
            xr_q   <= '0;
            br_q   <= '0;
            zero_q <= 1'b0;
        end else if (en_c) begin
            vld_q  <= vld_d;
            cry_q  <= cry_d;
            sum_q  <= sum_d;
            xr_q   <= xr_d;
            br_q   <= br_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = en_c;
    assign bus.out_valid = vld_q[NSEG-1];
    assign bus.sum       = sum_q[SUM_LO +: WIDTH];
    assign bus.cout      = cry_q[NSEG-1];
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Scoreboard bench for pipelined_seg_adder: driver pushes expected results,
// an independent monitor pops and compares on each output handshake.
module tb_pipelined_seg_adder;
    localparam int unsigned W   = 48;
    localparam int unsigned NS  = 4;
    localparam int unsigned LZW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]   sum;
        logic           cout;
        logic           zero;
        logic [LZW-1:0] lzc;
        int             acc;
        bit             strict;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_seg_adder_if #(.WIDTH(W)) bus ();
    pipelined_seg_adder #(.WIDTH(W), .NSEG(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   strict_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain (W+1)-bit modular arithmetic.
    function automatic exp_t model(input logic [W:0] xv, input logic [W-1:0] yv, input logic sv);
        exp_t       e;
        logic [W:0] r;
        r      = sv ? (xv - {1'b0, yv}) : (xv + {1'b0, yv});
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.zero = (r[W-1:0] == '0);
        e.lzc  = LZW'(W);
        for (int i = 0; i < int'(W); i++) if (r[i]) e.lzc = LZW'(int'(W) - 1 - i);
        e.acc    = 0;
        e.strict = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic z,
                                input logic [LZW-1:0] l);
        exp_t e;
        e.sum = s; e.cout = c; e.zero = z; e.lzc = l; e.acc = 0; e.strict = 1'b0;
        return e;
    endfunction

    // Present one beat from a negedge, hold until accepted, record its expectation.
    task automatic push_send(input logic [W:0] xv, input logic [W-1:0] yv, input logic sv,
                             input exp_t e);
        int t = 0;
        bus.x = xv; bus.y = yv; bus.sub = sv; bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            e.acc    = cyc;
            e.strict = strict_lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [W:0] xv, input logic [W-1:0] yv, input logic sv);
        push_send(xv, yv, sv, model(xv, yv, sv));
    endtask

    task automatic drain();
        int t = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: compares on out handshake, checks held results stay stable.
    initial begin : monitor
        exp_t           e;
        bit             hold = 1'b0;
        logic [W-1:0]   h_sum;
        logic           h_cout, h_zero;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_sum",   64'(bus.sum),  64'(h_sum));
                    chk("hold_cout",  64'(bus.cout), 64'(h_cout));
                    chk("hold_zero",  64'(bus.zero), 64'(h_zero));
                end
                hold = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL spurious: out_valid=1 with no beat outstanding, expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum",  64'(bus.sum),  64'(e.sum));
                        chk("cout", 64'(bus.cout), 64'(e.cout));
                        chk("zero", 64'(bus.zero), 64'(e.zero));
`ifdef SEG_ADDER_LZC_EN
                        chk("lzc",  64'(bus.lzc),  64'(e.lzc));
`endif
                        if (e.strict) chk("latency", 64'(cyc - e.acc), 64'(NS));
                    end
                end else if (bus.out_valid) begin
                    hold = 1'b1; h_sum = bus.sum; h_cout = bus.cout; h_zero = bus.zero;
                end
            end
        end
    end

    initial begin : stim
        logic [W:0]   xv;
        logic [W-1:0] yv;
        bit           done;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_sum",       64'(bus.sum),       64'd0);
        chk("rst_cout",      64'(bus.cout),      64'd0);
        chk("rst_zero",      64'(bus.zero),      64'd0);
`ifdef SEG_ADDER_LZC_EN
        chk("rst_lzc",       64'(bus.lzc),       64'd0);
`endif
        @(negedge clk);

        // Directed corner cases with hand-derived expectations.
        push_send(49'h0_FFFF_FFFF_FFFF, 48'd1, 1'b0, mk(48'd0, 1'b1, 1'b1, LZW'(48)));
        push_send(49'h1_0000_0000_0000, 48'd0, 1'b0, mk(48'd0, 1'b1, 1'b1, LZW'(48)));
        push_send(49'd5, 48'd7, 1'b1, mk(48'hFFFF_FFFF_FFFE, 1'b1, 1'b0, LZW'(0)));
        push_send(49'd7, 48'd7, 1'b1, mk(48'd0, 1'b0, 1'b1, LZW'(48)));
`ifdef SEG_ADDER_LZC_EN
        push_send(49'h0_0000_0001_0000, 48'd0, 1'b0, mk(48'h0000_0001_0000, 1'b0, 1'b0, LZW'(31)));
        push_send(49'd0, 48'd0, 1'b0, mk(48'd0, 1'b0, 1'b1, LZW'(48)));
`endif
        drain();

        // Back-to-back stream with exact latency check.
        strict_lat = 1'b1;
        for (int i = 0; i < 8; i++)
            push_send((W+1)'(i), W'(i), 1'b0, mk(W'(2 * i), 1'b0, (i == 0), LZW'(0)));
        strict_lat = 1'b0;
        // lzc of 2i is not constant; recompute the queued entries from the model.
        for (int i = 0; i < exp_q.size(); i++) exp_q[i].lzc = model((W+1)'(i), W'(i), 1'b0).lzc;
        drain();

        // Backpressure: stall the sink for 3 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) send((W+1)'(100 + 3 * i), W'(i), 1'(i % 2));
            end
            begin
                int t = 0;
                @(negedge clk); #1;
                while (!bus.out_valid && t < 50) begin @(negedge clk); #1; t++; end
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    #1;
                    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send((W+1)'(i + 1), W'(i + 1), 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (8) @(negedge clk);

        // Randomized traffic with random sink readiness and input bubbles.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    xv = (W+1)'({$urandom(), $urandom()});
                    yv = W'({$urandom(), $urandom()});
                    case ($urandom_range(0, 7))
                        0: xv = '1;
                        1: yv = '1;
                        2: begin xv = '0; yv = '0; end
                        3: yv = xv[W-1:0];
                        default: ;
                    endcase
                    if ($urandom_range(0, 4) == 0) @(negedge clk);
                    send(xv, yv, 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
